// File: rtl/bootloader_rx_pkg.sv
// Shared types and constants for the serial instruction loader.
package bootloader_rx_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 12;
    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned SHIFT_W        = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } bl_state_e;

    // Largest word count a header may announce: the full memory, 2^addr_w words.
    function automatic logic [SHIFT_W:0] hdr_limit(input int unsigned addr_w);
        return 33'(1) << addr_w;
    endfunction

endpackage

// File: rtl/bootloader_rx_sync.sv
// Pin synchronizers for the serial clock/data pair plus serial-clock rising-edge detect.
module bl_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic sclk_i,
    input  logic sdata_i,
    output logic sclk_rise_o,
    output logic sdata_o
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sdata_sync_q;
    logic                   sclk_prev_q;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            sclk_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata_i};
            sclk_prev_q  <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    // Equal chain depth keeps data aligned with the clock edge it belongs to.
    assign sclk_rise_o = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sdata_o     = sdata_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/bootloader_rx.sv
// Serial instruction loader: header N, N data words, optional checksum word
// (present when BOOTLOADER_CHECKSUM_EN is defined), written to imem from address 0.
module bootloader_rx
    import bootloader_rx_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_en,
    input  logic              bl_sclk,
    input  logic              bl_sdata,
    output logic              bl_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [SHIFT_W:0] HDR_LIMIT = hdr_limit(ADDR_W);

    bl_state_e           state_q, state_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                load_en_q;
`ifdef BOOTLOADER_CHECKSUM_EN
    logic [SHIFT_W-1:0]  sum_q, sum_d;
`endif

    logic                sclk_rise;
    logic                sdata_sync;
    logic                shifting;
    logic                word_done;
    logic                last_write;
    logic                abort;
    logic [SHIFT_W-1:0]  word_next;

    bl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk         (clk),
        .resetn      (resetn),
        .sclk_i      (bl_sclk),
        .sdata_i     (bl_sdata),
        .sclk_rise_o (sclk_rise),
        .sdata_o     (sdata_sync)
    );

    assign shifting   = sclk_rise && (state_q inside {ST_HDR, ST_DATA, ST_CSUM});
    assign word_next  = {shift_q[SHIFT_W-2:0], sdata_sync};
    assign word_done  = shifting && (bit_cnt_q == 5'd31);
    // Compare before incrementing so a full-memory load never wraps the address.
    assign last_write = ({1'b0, addr_q} + (ADDR_W+1)'(1)) == n_q;
    assign abort      = !load_en && (state_q inside {ST_HDR, ST_DATA, ST_WRITE, ST_CSUM});

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        n_d       = n_q;
        done_d    = done_q;
        error_d   = error_q;
`ifdef BOOTLOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        if (shifting) begin
            shift_d   = word_next;
            bit_cnt_d = bit_cnt_q + 5'd1;
        end

        if (abort) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_en && !load_en_q) begin
                        state_d   = ST_HDR;
                        done_d    = 1'b0;
                        error_d   = 1'b0;
                        bit_cnt_d = '0;
                        addr_d    = '0;
`ifdef BOOTLOADER_CHECKSUM_EN
                        sum_d     = '0;
`endif
                    end
                end
                ST_HDR: begin
                    if (word_done) begin
                        if (word_next == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else if ({1'b0, word_next} > HDR_LIMIT) begin
                            state_d = ST_ERR;
                            error_d = 1'b1;
                        end else begin
                            state_d = ST_DATA;
                            n_d     = word_next[ADDR_W:0];
                        end
                    end
                end
                ST_DATA: begin
                    if (word_done) state_d = ST_WRITE;
                end
                ST_WRITE: begin
`ifdef BOOTLOADER_CHECKSUM_EN
                    sum_d = sum_q + shift_q;
`endif
                    if (last_write) begin
`ifdef BOOTLOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = ST_DATA;
                        addr_d  = addr_q + 1'b1;
                    end
                end
`ifdef BOOTLOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (word_done) begin
                        if (word_next == sum_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_ERR;
                            error_d = 1'b1;
                        end
                    end
                end
`endif
                ST_DONE, ST_ERR: begin
                    if (!load_en) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            n_q       <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            load_en_q <= 1'b0;
`ifdef BOOTLOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            n_q       <= n_d;
            done_q    <= done_d;
            error_q   <= error_d;
            load_en_q <= load_en;
`ifdef BOOTLOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    // An abort coinciding with WRITE must not reach memory.
    assign imem_we    = (state_q == ST_WRITE) && load_en;
    assign imem_addr  = addr_q;
    assign imem_wdata = shift_q[DATA_W-1:0];
    assign bl_ready   = load_en && (state_q inside {ST_HDR, ST_DATA, ST_CSUM});
    assign busy       = state_q inside {ST_HDR, ST_DATA, ST_WRITE, ST_CSUM};
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_bootloader_rx.sv
// Self-checking bench for bootloader_rx: directed and random serial sessions against a frame-level model.
module tb_bootloader_rx;

    // A small address space keeps the full-memory session within a short run.
    localparam int AW     = 6;
    localparam int DW     = 32;
    localparam int SS     = 2;
    localparam int MIN_PH = SS + 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          load_en = 1'b0;
    logic          bl_sclk = 1'b0;
    logic          bl_sdata = 1'b0;
    logic          bl_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          busy;
    logic          done;
    logic          error;

    int tests = 0;
    int fails = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [31:0]   tx_q[$];
    int            we_long = 0;
    logic          we_prev = 1'b0;

    bootloader_rx #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .load_en    (load_en),
        .bl_sclk    (bl_sclk),
        .bl_sdata   (bl_sdata),
        .bl_ready   (bl_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
        if (imem_we && we_prev) we_long++;
        we_prev = imem_we;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int ph);
        @(negedge clk);
        bl_sdata = b;
        bl_sclk  = 1'b1;
        repeat (ph - 1) @(negedge clk);
        @(negedge clk);
        bl_sclk = 1'b0;
        repeat (ph - 1) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int nbits, input int ph);
        for (int i = 0; i < nbits; i++) send_bit(w[31-i], ph);
    endtask

    function automatic logic [31:0] sum_of(input int n);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < n; i++) s += tx_q[i];
        return s;
    endfunction

    // Model: the frame is accepted word by word; outcome follows from header size, abort point and checksum.
    task automatic run_session(input logic [31:0] hdr, input logic [31:0] csum, input int ph,
                               input int abort_at, input string tag);
        int          n_exp_wr = 0;
        logic        exp_done = 1'b0;
        logic        exp_err  = 1'b0;
        logic [31:0] sum      = 32'd0;

        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk);
        load_en = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, "/start"}, {bl_ready, busy, done, error}, 4'b1100);

        send_word(hdr, 32, ph);
        if (hdr == 32'd0) begin
            exp_done = 1'b1;
        end else if (hdr > 2 ** AW) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < int'(hdr); i++) begin
                if (i == abort_at) begin
                    send_word(tx_q[i], 20, ph);
                    @(negedge clk);
                    load_en = 1'b0;
                    exp_err = 1'b1;
                    break;
                end
                send_word(tx_q[i], 32, ph);
                sum += tx_q[i];
                n_exp_wr++;
            end
            if (!exp_err) begin
                send_word(csum, 32, ph);
`ifdef BOOTLOADER_CHECKSUM_EN
                if (csum == sum) exp_done = 1'b1;
                else             exp_err  = 1'b1;
`else
                exp_done = 1'b1;
`endif
            end
        end

        repeat (6) @(negedge clk);
        check({tag, "/end"}, {busy, done, error}, {1'b0, exp_done, exp_err});
        check({tag, "/nwr"}, wr_addr_q.size(), n_exp_wr);
        for (int i = 0; i < n_exp_wr && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s/addr%0d", tag, i), wr_addr_q[i], i);
            check($sformatf("%s/data%0d", tag, i), wr_data_q[i], tx_q[i]);
        end

        load_en = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "/idle"}, {bl_ready, busy, done, error}, {2'b00, exp_done, exp_err});
    endtask

    initial begin
        logic [31:0] cs;
        int          n;

        repeat (3) @(negedge clk);
        check("reset", {bl_ready, busy, done, error, imem_we, imem_addr, imem_wdata}, '0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", {bl_ready, busy}, 2'b00);

        tx_q = '{32'h00500013, 32'h00A00093, 32'hDEADBEEF};
        run_session(32'd3, sum_of(3), MIN_PH, -1, "prog3");
        run_session(32'd0, 32'd0, MIN_PH, -1, "hdr0");
        run_session(32'd4097, 32'd0, MIN_PH, -1, "hdr4097");
        run_session(32'(2 ** AW + 1), 32'd0, MIN_PH, -1, "hdr_limit_p1");

        tx_q = '{$urandom, $urandom, $urandom};
        run_session(32'd3, sum_of(3), MIN_PH, 1, "abort");

        tx_q = '{32'd1, 32'd2};
        run_session(32'd2, 32'd3, MIN_PH, -1, "csum_ok");
        run_session(32'd2, 32'd4, MIN_PH, -1, "csum_bad");

        for (int s = 0; s < 6; s++) begin
            n = $urandom_range(1, 5);
            tx_q.delete();
            for (int i = 0; i < n; i++) tx_q.push_back($urandom);
            cs = sum_of(n);
            if ($urandom_range(0, 1) == 1) cs ^= 32'(1) << $urandom_range(0, 31);
            run_session(32'(n), cs, $urandom_range(MIN_PH, MIN_PH + 2), -1, $sformatf("rand%0d", s));
        end

        tx_q.delete();
        for (int i = 0; i < 2 ** AW; i++) tx_q.push_back($urandom);
        run_session(32'(2 ** AW), sum_of(2 ** AW), MIN_PH, -1, "full");
        check("full/final_addr", wr_addr_q.size() > 0 ? wr_addr_q[$] : '0, 2 ** AW - 1);

        @(negedge clk);
        load_en = 1'b1;
        repeat (2) @(negedge clk);
        send_word(32'd2, 32, MIN_PH);
        send_word(32'hA5A5A5A5, 10, MIN_PH);
        #3;
        resetn  = 1'b0;
        load_en = 1'b0;
        #1;
        check("async_reset", {bl_ready, busy, done, error, imem_we, imem_addr, imem_wdata}, '0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", {bl_ready, busy}, 2'b00);

        check("we_single_cycle", we_long, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
